// File: rtl/gate_activation.sv
// Serial PLAN sigmoid/tanh stage for an LSTM gate: latches a packed pre-activation
// vector and writes one activated element per cycle through a 2-stage pipeline.
module gate_activation #(
  parameter int HIDDEN_SZ = 16,
  parameter int QN        = 6,
  parameter int QM        = 11,
  localparam int BITWIDTH       = QN + QM + 1,
  localparam int LAYER_BITWIDTH = BITWIDTH * HIDDEN_SZ
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      beginAct,
  input  logic                      mode,
  input  logic [LAYER_BITWIDTH-1:0] gateOutput,
  output logic                      busy,
  output logic                      dataReady_act,
  output logic [LAYER_BITWIDTH-1:0] actOutput
);

  localparam int IDX_W = (HIDDEN_SZ > 1) ? $clog2(HIDDEN_SZ) : 1;
  localparam int SW    = QM + 1;  // segment value spans [0, ONE]
  localparam int ONE   = 1 << QM;

  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(HIDDEN_SZ - 1);
  localparam logic [BITWIDTH:0]     SAT_MAG  = {2'b00, {(BITWIDTH-1){1'b1}}};
  localparam logic [BITWIDTH-2:0]   A_SAT    = (BITWIDTH-1)'(5 * ONE);
  localparam logic [BITWIDTH-2:0]   A_HI     = (BITWIDTH-1)'(19 * ONE / 8);
  localparam logic [BITWIDTH-2:0]   A_MID    = (BITWIDTH-1)'(ONE);
  localparam logic [SW-1:0]         ONE_S    = SW'(ONE);
  localparam logic [SW-1:0]         OFF_HI   = SW'(27 * ONE / 32);
  localparam logic [SW-1:0]         OFF_MID  = SW'(5 * ONE / 8);
  localparam logic [SW-1:0]         OFF_LO   = SW'(ONE / 2);
  localparam logic signed [BITWIDTH-1:0] ONE_W = BITWIDTH'(ONE);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                    state_q;
  logic                      busy_q, rdy_q, mode_q;
  logic [LAYER_BITWIDTH-1:0] vec_q, act_q;
  logic [IDX_W-1:0]          idx_q, idx1_q;
  logic                      v1_q, neg1_q;
  logic [SW-1:0]             s1_q;

  logic signed [BITWIDTH-1:0] x;
  logic signed [BITWIDTH:0]   xs;
  logic [BITWIDTH:0]          mag;
  logic [BITWIDTH-2:0]        a;
  logic [SW-1:0]              s_d;
  logic                       neg_d;
  logic signed [BITWIDTH-1:0] sx, t, y_d;

  // Stage 1: magnitude (doubled for tanh), saturation and segment lookup.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    x     = vec_q[idx_q*BITWIDTH +: BITWIDTH];
    neg_d = x[BITWIDTH-1];
    xs    = mode_q ? {x, 1'b0} : {x[BITWIDTH-1], x};
    mag   = xs[BITWIDTH] ? (~xs + 1'b1) : xs;
    a     = (mag > SAT_MAG) ? SAT_MAG[BITWIDTH-2:0] : mag[BITWIDTH-2:0];
    s_d   = OFF_LO;
    if (a >= A_SAT)      s_d = ONE_S;
    else if (a >= A_HI)  s_d = SW'(a >> 5) + OFF_HI;
    else if (a >= A_MID) s_d = SW'(a >> 3) + OFF_MID;
    else                 s_d = SW'(a >> 2) + OFF_LO;
  end

  // Stage 2: sign fold; results are always in range, so no output clamp.
  always_comb begin
    sx  = BITWIDTH'(s1_q);
    t   = (sx <<< 1) - ONE_W;
    y_d = sx;
    if (mode_q) y_d = neg1_q ? -t : t;
    else        y_d = neg1_q ? (ONE_W - sx) : sx;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
      mode_q  <= 1'b0;
      vec_q   <= '0;
      act_q   <= '0;
      idx_q   <= '0;
      idx1_q  <= '0;
      v1_q    <= 1'b0;
      neg1_q  <= 1'b0;
      s1_q    <= '0;
    end else begin
      rdy_q <= 1'b0;
      v1_q  <= 1'b0;
      if (v1_q) act_q[idx1_q*BITWIDTH +: BITWIDTH] <= y_d;
      case (state_q)
        IDLE: begin
          if (beginAct) begin
            vec_q   <= gateOutput;
            mode_q  <= mode;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          s1_q   <= s_d;
          neg1_q <= neg_d;
          idx1_q <= idx_q;
          v1_q   <= 1'b1;
          idx_q  <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) state_q <= DRAIN;
        end
        DRAIN: begin
          busy_q  <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign dataReady_act = rdy_q;
  assign actOutput     = act_q;

endmodule

// File: tb/tb_gate_activation.sv
// Self-checking bench for gate_activation: directed PLAN points, protocol corner cases
// and randomized vectors compared against an integer reference model.
module tb_gate_activation;

  localparam int HS = 16;
  localparam int BW = 18;
  localparam int LW = HS * BW;

  logic          clock = 1'b0;
  logic          reset, beginAct, mode;
  logic [LW-1:0] gateOutput;
  logic          busy, dataReady_act;
  logic [LW-1:0] actOutput;

  int n_tests = 0;
  int n_fail  = 0;

  gate_activation dut (
    .clock(clock), .reset(reset), .beginAct(beginAct), .mode(mode),
    .gateOutput(gateOutput), .busy(busy), .dataReady_act(dataReady_act),
    .actOutput(actOutput)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: PLAN rules in plain integer arithmetic.
  function automatic int model_act(int x, bit m);
    int a, s, t;
    a = m ? 2 * x : x;
    if (a < 0) a = -a;
    if (a > 131071) a = 131071;
    if (a >= 10240)     s = 2048;
    else if (a >= 4864) s = a / 32 + 1728;
    else if (a >= 2048) s = a / 8 + 1280;
    else                s = a / 4 + 1024;
    if (!m) return (x >= 0) ? s : 2048 - s;
    t = 2 * s - 2048;
    return (x >= 0) ? t : -t;
  endfunction

  function automatic int get_el(logic [LW-1:0] v, int i);
    logic signed [BW-1:0] e;
    e = v[i*BW +: BW];
    return int'(e);
  endfunction

  function automatic logic [LW-1:0] set_el(logic [LW-1:0] v, int i, int val);
    logic [LW-1:0] r;
    r = v;
    r[i*BW +: BW] = BW'(val);
    return r;
  endfunction

  // Caller is at a negedge; returns at the negedge right after the start edge.
  task automatic do_start(logic [LW-1:0] vec, bit m);
    beginAct   = 1'b1;
    gateOutput = vec;
    mode       = m;
    @(negedge clock);
    beginAct = 1'b0;
  endtask

  // Observes from k0+1 to k=18 edges after the start edge, then checks latency,
  // single pulse and busy profile.
  task automatic wait_done(string name, int k0);
    int lat = -1, pulses = 0, busy_err = 0;
    for (int k = k0 + 1; k <= 18; k++) begin
      @(negedge clock);
      if (dataReady_act) begin
        pulses++;
        if (lat < 0) lat = k;
      end
      if (busy !== (k <= 16)) busy_err++;
    end
    n_tests++;
    if (lat !== 17) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges, expected 17", name, lat);
    end
    n_tests++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL %s pulse_count: got %0d, expected 1", name, pulses);
    end
    if (k0 == 0) begin
      n_tests++;
      if (busy_err !== 0) begin
        n_fail++;
        $display("FAIL %s busy_profile: %0d bad cycles, expected 0", name, busy_err);
      end
    end
  endtask

  task automatic check_vec(string name, logic [LW-1:0] vec, bit m);
    int got, exp;
    for (int i = 0; i < HS; i++) begin
      got = get_el(actOutput, i);
      exp = model_act(get_el(vec, i), m);
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s elem%0d (x=%0d mode=%0d): got %0d, expected %0d",
                 name, i, get_el(vec, i), m, got, exp);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; beginAct = 1'b0; mode = 1'b0; gateOutput = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    n_tests++;
    if ({busy, dataReady_act} !== 2'b00 || actOutput !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b rdy=%b act=%h, expected 0/0/0",
               busy, dataReady_act, actOutput);
    end
  endtask

  task automatic test_sigmoid_zero();
    logic [LW-1:0] v = '0;
    do_start(v, 1'b0);
    wait_done("sig_zero", 0);
    for (int i = 0; i < HS; i++) begin
      n_tests++;
      if (get_el(actOutput, i) !== 1024) begin
        n_fail++;
        $display("FAIL sig_zero elem%0d: got %0d, expected 1024", i, get_el(actOutput, i));
      end
    end
  endtask

  task automatic test_sigmoid_points();
    int xs [5] = '{2048, -2048, 4864, 10240, -131072};
    int ys [5] = '{1536, 512, 1880, 2048, 0};
    logic [LW-1:0] v = '0;
    for (int i = 0; i < 5; i++) v = set_el(v, i, xs[i]);
    do_start(v, 1'b0);
    wait_done("sig_pts", 0);
    for (int i = 0; i < HS; i++) begin
      n_tests++;
      if (get_el(actOutput, i) !== ((i < 5) ? ys[i] : 1024)) begin
        n_fail++;
        $display("FAIL sig_pts elem%0d: got %0d, expected %0d", i,
                 get_el(actOutput, i), (i < 5) ? ys[i] : 1024);
      end
    end
  endtask

  task automatic test_tanh_points();
    int xs [5] = '{1024, -1024, 2048, 131071, 0};
    int ys [5] = '{1024, -1024, 1536, 2048, 0};
    logic [LW-1:0] v = '0;
    for (int i = 0; i < 5; i++) v = set_el(v, i, xs[i]);
    v = set_el(v, 5, -131072);
    do_start(v, 1'b1);
    wait_done("tanh_pts", 0);
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (get_el(actOutput, i) !== ys[i]) begin
        n_fail++;
        $display("FAIL tanh_pts elem%0d: got %0d, expected %0d", i, get_el(actOutput, i), ys[i]);
      end
    end
    n_tests++;
    if (get_el(actOutput, 5) !== -2048) begin
      n_fail++;
      $display("FAIL tanh_most_neg: got %0d, expected -2048", get_el(actOutput, 5));
    end
  endtask

  task automatic test_ignore_restart();
    logic [LW-1:0] v = '0;
    for (int i = 0; i < HS; i++) v = set_el(v, i, $urandom_range(0, 24000) - 12000);
    do_start(v, 1'b0);
    repeat (5) @(negedge clock);
    beginAct = 1'b1; mode = 1'b1; gateOutput = ~v;
    repeat (2) @(negedge clock);
    beginAct = 1'b0;
    wait_done("ignore", 7);
    check_vec("ignore", v, 1'b0);
  endtask

  task automatic test_reset_abort();
    logic [LW-1:0] v = '0;
    int pulses = 0;
    for (int i = 0; i < HS; i++) v = set_el(v, i, $urandom_range(0, 8000) - 4000);
    do_start(v, 1'b1);
    repeat (7) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_tests++;
    if (busy !== 1'b0 || actOutput !== '0) begin
      n_fail++;
      $display("FAIL abort_state: busy=%b act=%h, expected 0 and 0", busy, actOutput);
    end
    if (dataReady_act) pulses++;
    reset = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (dataReady_act) pulses++;
    end
    n_tests++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL abort_no_pulse: got %0d pulses, expected 0", pulses);
    end
    do_start(v, 1'b0);
    wait_done("after_abort", 0);
    check_vec("after_abort", v, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [LW-1:0] va = '0, vb = '0;
    for (int i = 0; i < HS; i++) begin
      va = set_el(va, i, $urandom_range(0, 16000) - 8000);
      vb = set_el(vb, i, $urandom_range(0, 16000) - 8000);
    end
    do_start(va, 1'b1);
    wait_done("b2b_first", 0);
    check_vec("b2b_first", va, 1'b1);
    do_start(vb, 1'b0);
    repeat (5) @(negedge clock);
    n_tests++;
    if (get_el(actOutput, 0) !== model_act(get_el(vb, 0), 1'b0)) begin
      n_fail++;
      $display("FAIL b2b_new_elem0: got %0d, expected %0d", get_el(actOutput, 0),
               model_act(get_el(vb, 0), 1'b0));
    end
    n_tests++;
    if (get_el(actOutput, 10) !== model_act(get_el(va, 10), 1'b1)) begin
      n_fail++;
      $display("FAIL b2b_old_elem10: got %0d, expected %0d", get_el(actOutput, 10),
               model_act(get_el(va, 10), 1'b1));
    end
    wait_done("b2b_second", 5);
    check_vec("b2b_second", vb, 1'b0);
  endtask

  task automatic test_random();
    int edges [15] = '{0, 1023, 1024, 2047, 2048, 2431, 2432, 4863, 4864,
                       5119, 5120, 10239, 10240, 131071, 65536};
    logic [LW-1:0] v;
    bit m;
    int x;
    for (int n = 0; n < 12; n++) begin
      v = '0;
      m = 1'($urandom_range(0, 1));
      for (int i = 0; i < HS; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          x = edges[$urandom_range(0, 14)];
          if ($urandom_range(0, 1) == 1) x = -x;
        end else begin
          x = $urandom_range(0, 262143) - 131072;
        end
        v = set_el(v, i, x);
      end
      do_start(v, m);
      wait_done("random", 0);
      check_vec("random", v, m);
      @(negedge clock);
    end
  endtask

  initial begin
    reset = 1'b1; beginAct = 1'b0; mode = 1'b0; gateOutput = '0;
    @(negedge clock);
    test_reset();
    test_sigmoid_zero();
    test_sigmoid_points();
    test_tanh_points();
    test_ignore_restart();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_activation.md
Name: gate_activation

Overview:
- Element-wise nonlinearity stage directly downstream of the LSTM gate pre-activation unit.
- Latches the packed HIDDEN_SZ-element pre-activation vector when the gate's ready pulse arrives.
- Applies a piecewise-linear (PLAN) sigmoid or tanh serially through a 2-stage pipeline, one element per cycle.
- Presents the packed activated vector to the cell-state update logic with a one-cycle ready pulse.

Parameters:
- HIDDEN_SZ, 16, number of elements in the vector.
- QN, 6, integer bits of the signed fixed-point format.
- QM, 11, fractional bits; ONE = 2^QM = 2048.
- BITWIDTH (derived), QN+QM+1 = 18, element width.
- LAYER_BITWIDTH (derived), BITWIDTH*HIDDEN_SZ, packed vector width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- beginAct  in  1  start request; connected to the gate's dataReady_gate.
- mode  in  1  0 = sigmoid, 1 = tanh; sampled with beginAct.
- gateOutput  in  LAYER_BITWIDTH  packed signed pre-activations; element i occupies bits [i*BITWIDTH +: BITWIDTH].
- busy  out  1  high while a vector is in flight.
- dataReady_act  out  1  one-cycle pulse when actOutput is complete.
- actOutput  out  LAYER_BITWIDTH  packed signed activations, same packing and format.

Behaviour:
- Reset: state IDLE, busy=0, dataReady_act=0, actOutput=0, element index=0, pipeline valids cleared.
- Reset mid-operation aborts the vector: no dataReady_act pulse, actOutput zeroed.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: on beginAct=1 at edge T, latch gateOutput and mode into internal registers, set idx=0, go to RUN, set busy=1.
- RUN: at each edge, stage 1 captures element idx from the latched vector; idx increments. After idx=HIDDEN_SZ-1 is issued, go to DRAIN.
- DRAIN: one edge for stage 2 to write the last element, then go to DONE.
- DONE: dataReady_act=1 for exactly one cycle and busy=0; next state IDLE.
- Timing: the element captured in stage 1 at edge e is written to actOutput at edge e+1. With start at edge T, element i is written at edge T+i+2.
- dataReady_act is high in the cycle following edge T+HIDDEN_SZ+1, i.e. 17 edges after the start edge for the defaults.
- beginAct while busy or in DONE is ignored; gateOutput changes after the start edge have no effect.
- actOutput holds its value until the next accepted start. Elements are then overwritten progressively, not cleared.
- Stage 1, for element x:
  - sigmoid mode: a = |x|.
  - tanh mode: a = |2x|.
  - |most-negative| saturates to 2^(BITWIDTH-1)-1; 2x saturates the same way.
- Stage 1, segment function s(a), with shifts as floor on non-negative values:
  - a >= 5.0 (10240): s = ONE.
  - 2.375 (4864) <= a < 5.0: s = (a>>5) + 1728.
  - 1.0 (2048) <= a < 2.375: s = (a>>3) + 1280.
  - a < 1.0: s = (a>>2) + 1024.
- Stage 2, sign fold and output:
  - sigmoid: y = s if x >= 0, else ONE - s.
  - tanh: t = 2s - ONE; y = t if x >= 0, else -t.
- Output range: all results lie in [0, ONE] for sigmoid and [-ONE, ONE] for tanh, so no output saturation is required.
- mode is constant for the whole vector.

Test Plan:
- Sigmoid, all elements 0; pulse beginAct at edge T -> dataReady_act high exactly one cycle after edge T+17; every element is 1024; busy high from T+1 through DRAIN.
- Sigmoid, elements 2048, -2048, 4864, 10240, -131072 (rest 0) -> 1536, 512, 1880, 2048, 0, rest 1024.
- Tanh, elements 1024, -1024, 2048, 131071, 0 -> 1024, -1024, 1536, 2048, 0.
- Second beginAct and mode toggle mid-RUN, plus changed gateOutput -> ignored; results match the originally latched vector and mode; single dataReady_act.
- Reset asserted at edge T+8 -> at the next cycle busy=0 and actOutput=0; no dataReady_act; a following beginAct runs a clean vector with the nominal 17-edge latency.
- Back-to-back: beginAct in the cycle after dataReady_act -> accepted; second vector correct; the first vector's values persist in elements not yet overwritten.
